// File: rtl/abs_acc_pkg.sv
// Package for the abs_acc block: the width helpers shared by the
// interface and the top level.
//   clog2_f    ceiling log2 of a positive integer
//   acc_width  accumulator width: magnitude bits plus window growth bits
//   cnt_width  width of the shared sample counter (at least one bit)
package abs_acc_pkg;

    function automatic int clog2_f(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // The magnitude of a WIDTH-bit signed sample fits in WIDTH-1 bits, and
    // summing ACC_LEN of them grows the result by clog2(ACC_LEN) bits.
    function automatic int acc_width(input int width, input int acc_len);
        return (width - 1) + clog2_f(acc_len);
    endfunction

    function automatic int cnt_width(input int acc_len);
        int w;
        w = clog2_f(acc_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/abs_acc_if.sv
// Bus interface of abs_acc: sample input side and result output side.
//   we         sample strobe, common to all channels
//   in         CH packed signed samples, channel k at [k*WIDTH +: WIDTH]
//   clr        restart the accumulation window
//   abs_out    CH packed saturated magnitudes, WIDTH-1 bits each
//   sat        per-channel saturation flag for abs_out
//   abs_valid  qualifies abs_out / sat
//   acc_out    CH packed window sums, AW bits each
//   acc_valid  one-cycle pulse qualifying a new acc_out
// Modports: master drives samples (bench / upstream), slave is the block.
interface abs_acc_if
    import abs_acc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CH      = 2,
    parameter int ACC_LEN = 1024
);
    localparam int AW = acc_width(WIDTH, ACC_LEN);

    logic                     we;
    logic [CH*WIDTH-1:0]      in;
    logic                     clr;
    logic [CH*(WIDTH-1)-1:0]  abs_out;
    logic [CH-1:0]            sat;
    logic                     abs_valid;
    logic [CH*AW-1:0]         acc_out;
    logic                     acc_valid;

    modport master (
        output we, in, clr,
        input  abs_out, sat, abs_valid, acc_out, acc_valid
    );

    modport slave (
        input  we, in, clr,
        output abs_out, sat, abs_valid, acc_out, acc_valid
    );
endinterface

// File: rtl/abs_acc_sat.sv
// abs_sat: one channel's registered saturated magnitude.
//   clk, resetn  clock and synchronous active-low reset
//   i_we         sample strobe; outputs hold while low
//   i_in         signed WIDTH-bit sample
//   o_mag_p1     |i_in| in WIDTH-1 bits, saturated for the most negative code
//   o_sat_p1     high when o_mag_p1 was saturated
module abs_sat #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    i_we,
    input  logic signed [WIDTH-1:0] i_in,
    output logic [WIDTH-2:0]        o_mag_p1,
    output logic                    o_sat_p1
);
    localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Returns {sat, magnitude}. -2^(WIDTH-1) has no positive counterpart in
    // WIDTH-1 bits, so it clamps to the all-ones magnitude.
    function automatic logic [WIDTH-1:0] sat_mag(input logic signed [WIDTH-1:0] x);
        logic signed [WIDTH-1:0] neg;
        neg = -x;
        if (x == MIN_VAL)
            return {1'b1, {(WIDTH-1){1'b1}}};
        else if (x < 0)
            return {1'b0, neg[WIDTH-2:0]};
        else
            return {1'b0, x[WIDTH-2:0]};
    endfunction

    logic [WIDTH-1:0] w_sm_p0;
    logic [WIDTH-2:0] r_mag_p1;
    logic             r_sat_p1;

    assign w_sm_p0 = sat_mag(i_in);

    // p0 -> p1: register magnitude on strobe
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mag_p1 <= '0;
            r_sat_p1 <= 1'b0;
        end else if (i_we) begin
            r_mag_p1 <= w_sm_p0[WIDTH-2:0];
            r_sat_p1 <= w_sm_p0[WIDTH-1];
        end
    end

    assign o_mag_p1 = r_mag_p1;
    assign o_sat_p1 = r_sat_p1;
endmodule

// File: rtl/abs_acc.sv
// abs_acc: per-channel saturated magnitude followed by windowed summation.
// Each window covers ACC_LEN qualified magnitudes; gaps in the strobe only
// stretch the window in time. A completed window loads acc_out and pulses
// acc_valid one cycle later while the next window starts seamlessly.
//   clk     sole clock, rising edge
//   resetn  synchronous active-low reset
//   bus     abs_acc_if slave: we/in/clr in, abs_*/acc_* out
module abs_acc
    import abs_acc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CH      = 2,
    parameter int ACC_LEN = 1024
) (
    input logic      clk,
    input logic      resetn,
    abs_acc_if.slave bus
);
    localparam int AW = acc_width(WIDTH, ACC_LEN);
    localparam int CW = cnt_width(ACC_LEN);
    localparam int MW = WIDTH - 1;

    logic [MW-1:0] w_abs_p1 [CH];
    logic          w_sat_p1 [CH];
    logic [AW-1:0] w_acc_out_p2 [CH];

    logic          r_abs_valid_p1;
    logic [CW-1:0] r_cnt_p2;
    logic          r_acc_valid_p2;
    logic          w_last_p1;

    // p0 -> p1: magnitude stage, one abs_sat per channel
    generate
        for (genvar k = 0; k < CH; k++) begin : g_sat
            abs_sat #(.WIDTH(WIDTH)) u_abs_sat (
                .clk      (clk),
                .resetn   (resetn),
                .i_we     (bus.we),
                .i_in     (bus.in[k*WIDTH +: WIDTH]),
                .o_mag_p1 (w_abs_p1[k]),
                .o_sat_p1 (w_sat_p1[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!resetn)
            r_abs_valid_p1 <= 1'b0;
        else
            r_abs_valid_p1 <= bus.we;
    end

    // The last sample of a window is the qualified one seen at count ACC_LEN-1.
    assign w_last_p1 = r_abs_valid_p1 && (r_cnt_p2 == CW'(ACC_LEN - 1));

    // p1 -> p2: shared sample counter and completion pulse.
    // clr has priority over completion so a coincident clear suppresses it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt_p2       <= '0;
            r_acc_valid_p2 <= 1'b0;
        end else begin
            r_acc_valid_p2 <= 1'b0;
            if (bus.clr) begin
                r_cnt_p2 <= '0;
            end else if (r_abs_valid_p1) begin
                if (w_last_p1) begin
                    r_cnt_p2       <= '0;
                    r_acc_valid_p2 <= 1'b1;
                end else begin
                    r_cnt_p2 <= r_cnt_p2 + CW'(1);
                end
            end
        end
    end

    // p1 -> p2: per-channel accumulators
    generate
        for (genvar k = 0; k < CH; k++) begin : g_acc
            logic [AW-1:0] r_acc_p2;
            logic [AW-1:0] r_acc_out_p2;
            logic [AW-1:0] w_sum_p1;

            assign w_sum_p1 = r_acc_p2 + AW'(w_abs_p1[k]);

            // On completion the final sample goes straight into acc_out and
            // the accumulator restarts from zero, so no sample is lost.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_acc_p2     <= '0;
                    r_acc_out_p2 <= '0;
                end else if (bus.clr) begin
                    r_acc_p2 <= '0;
                end else if (r_abs_valid_p1) begin
                    if (w_last_p1) begin
                        r_acc_out_p2 <= w_sum_p1;
                        r_acc_p2     <= '0;
                    end else begin
                        r_acc_p2 <= w_sum_p1;
                    end
                end
            end

            assign w_acc_out_p2[k] = r_acc_out_p2;
        end
    endgenerate

    always_comb begin
        bus.abs_out = '0;
        bus.sat     = '0;
        bus.acc_out = '0;
        for (int k = 0; k < CH; k++) begin
            bus.abs_out[k*MW +: MW] = w_abs_p1[k];
            bus.sat[k]              = w_sat_p1[k];
            bus.acc_out[k*AW +: AW] = w_acc_out_p2[k];
        end
    end

    assign bus.abs_valid = r_abs_valid_p1;
    assign bus.acc_valid = r_acc_valid_p2;
endmodule
